// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM arbiter: transfer state encoding and the helper
// that locates a port's field inside a packed per-port bus.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side and SDRAM-controller-side signals of the RAM arbiter.
// slave is the arbiter's view; master is the view of whatever drives it.
interface ram_arbiter_if #(
    parameter int N_REQ      = 3,
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int ID_WIDTH = $clog2(N_REQ);

    logic [N_REQ-1:0]            REQ;
    logic [N_REQ-1:0]            REQ_WE;
    logic [N_REQ*ADDR_WIDTH-1:0] REQ_ADDR;
    logic [N_REQ*DATA_WIDTH-1:0] REQ_DIN;
    logic [N_REQ*BE_WIDTH-1:0]   REQ_BE;
    logic [N_REQ-1:0]            ACK;
    logic [DATA_WIDTH-1:0]       DOUT;
    logic [ID_WIDTH-1:0]         GRANT_ID;
    logic                        BUSY;

    logic                        MEM_REQ;
    logic                        MEM_WE;
    logic [ADDR_WIDTH-1:0]       MEM_ADDR;
    logic [DATA_WIDTH-1:0]       MEM_DIN;
    logic [BE_WIDTH-1:0]         MEM_BE;
    logic                        MEM_ACK;
    logic [DATA_WIDTH-1:0]       MEM_DOUT;

    modport slave (
        input  REQ, REQ_WE, REQ_ADDR, REQ_DIN, REQ_BE, MEM_ACK, MEM_DOUT,
        output ACK, DOUT, GRANT_ID, BUSY, MEM_REQ, MEM_WE, MEM_ADDR, MEM_DIN, MEM_BE
    );

    modport master (
        output REQ, REQ_WE, REQ_ADDR, REQ_DIN, REQ_BE, MEM_ACK, MEM_DOUT,
        input  ACK, DOUT, GRANT_ID, BUSY, MEM_REQ, MEM_WE, MEM_ADDR, MEM_DIN, MEM_BE
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search over ports 1..N_REQ-1, starting after
// 'last' and wrapping from N_REQ-1 back to 1; port 0 is never a candidate.
module rr_pick #(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:1]         mask,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic                     valid,
    output logic [$clog2(N_REQ)-1:0] index
);
    localparam int ID_WIDTH = $clog2(N_REQ);

    int base;
    int cand;

    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = 1;
        // A 'last' of 0 cannot come from a round-robin grant; treat it as the top port.
        base  = (last == '0) ? (N_REQ - 1) : int'(last);
        for (int k = 1; k < N_REQ; k++) begin
            cand = ((base - 1 + k) % (N_REQ - 1)) + 1;
            if (!valid && mask[cand]) begin
                valid = 1'b1;
                index = ID_WIDTH'(cand);
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates N_REQ requesters onto one SDRAM controller: port 0 has priority,
// bounded by a starvation counter, ports 1..N_REQ-1 share round-robin.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N_REQ        = 3,
    parameter int ADDR_WIDTH   = 22,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    ram_arbiter_if.slave  bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int ID_WIDTH = $clog2(N_REQ);
    localparam int SW       = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
    logic [N_REQ-1:0]      ack_q, ack_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  busy_q, busy_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
    logic [BE_WIDTH-1:0]   mem_be_q, mem_be_d;
    logic [ID_WIDTH-1:0]   last_rr_q, last_rr_d;
    logic [SW-1:0]         starve_q, starve_d;

    logic                  rr_valid;
    logic [ID_WIDTH-1:0]   rr_index;
    logic [ID_WIDTH-1:0]   win;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .mask  (bus.REQ[N_REQ-1:1]),
        .last  (last_rr_q),
        .valid (rr_valid),
        .index (rr_index)
    );

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        ack_d      = '0;
        dout_d     = dout_q;
        busy_d     = busy_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_be_d   = mem_be_q;
        last_rr_d  = last_rr_q;
        starve_d   = starve_q;
        win        = '0;

        case (state_q)
            IDLE: begin
                if (|bus.REQ) begin
                    // rr_valid doubles as "some other port is requesting".
                    if (bus.REQ[0] && !(starve_q == STARVE_MAX && rr_valid)) begin
                        win = '0;
                        if (!rr_valid) begin
                            starve_d = '0;
                        end else if (starve_q != STARVE_MAX) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end else begin
                        win       = rr_index;
                        last_rr_d = rr_index;
                        starve_d  = '0;
                    end
                    grant_id_d = win;
                    mem_we_d   = bus.REQ_WE[win];
                    mem_addr_d = bus.REQ_ADDR[slice_lo(int'(win), ADDR_WIDTH) +: ADDR_WIDTH];
                    mem_din_d  = bus.REQ_DIN[slice_lo(int'(win), DATA_WIDTH) +: DATA_WIDTH];
                    mem_be_d   = bus.REQ_BE[slice_lo(int'(win), BE_WIDTH) +: BE_WIDTH];
                    mem_req_d  = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.MEM_ACK) begin
                    dout_d            = bus.MEM_DOUT;
                    ack_d[grant_id_q] = 1'b1;
                    mem_req_d         = 1'b0;
                    state_d           = COMPLETE;
                end
            end
            COMPLETE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d    = 1'b0;
                mem_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            ack_q      <= '0;
            dout_q     <= '0;
            busy_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_be_q   <= '0;
            last_rr_q  <= ID_WIDTH'(N_REQ - 1);
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            ack_q      <= ack_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_be_q   <= mem_be_d;
            last_rr_q  <= last_rr_d;
            starve_q   <= starve_d;
        end
    end

    assign bus.ACK      = ack_q;
    assign bus.DOUT     = dout_q;
    assign bus.GRANT_ID = grant_id_q;
    assign bus.BUSY     = busy_q;
    assign bus.MEM_REQ  = mem_req_q;
    assign bus.MEM_WE   = mem_we_q;
    assign bus.MEM_ADDR = mem_addr_q;
    assign bus.MEM_DIN  = mem_din_q;
    assign bus.MEM_BE   = mem_be_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level arbitration model.
module tb_ram_arbiter;
    localparam int N = 3, AW = 22, DW = 32, BW = 4, LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad   = 0;
    int m_last, m_starve;

    ram_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .CLK(clk), .RESET(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at limit, required finish");
        $fatal(1);
    end

    // Arbitration rules: port 0 first unless starved-out, otherwise first port after last_rr.
    function automatic int model_pick(input logic [N-1:0] mask);
        int  p;
        bit  others;
        others = (mask[N-1:1] != '0);
        if (mask[0] && !(m_starve == LIMIT && others)) begin
            if (!others) m_starve = 0;
            else if (m_starve < LIMIT) m_starve = m_starve + 1;
            return 0;
        end
        p = m_last;
        for (int k = 1; k < N; k++) begin
            p = (p % (N - 1)) + 1;
            if (mask[p]) begin
                m_last   = p;
                m_starve = 0;
                return p;
            end
        end
        return -1;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.REQ = '0; bus.REQ_WE = '0; bus.REQ_ADDR = '0; bus.REQ_DIN = '0; bus.REQ_BE = '0;
        bus.MEM_ACK = 1'b0; bus.MEM_DOUT = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) tick();
        rst = 1'b0;
        m_last = N - 1;
        m_starve = 0;
    endtask

    task automatic set_cmd(input int p, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [BW-1:0] be);
        bus.REQ_WE[p] = we;
        bus.REQ_ADDR[p*AW +: AW] = a;
        bus.REQ_DIN[p*DW +: DW] = d;
        bus.REQ_BE[p*BW +: BW] = be;
    endtask

    task automatic rand_cmd(input int p);
        set_cmd(p, 1'($urandom_range(0, 1)), AW'($urandom), $urandom, BW'($urandom));
    endtask

    // Plays the SDRAM controller for one transfer; returns at the ACK cycle.
    task automatic serve(input int lat, input logic [DW-1:0] d,
                         output int gid, output int waited, output bit ok);
        ok = 1'b0; waited = 0; gid = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus.MEM_REQ === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
            waited++;
        end
        if (!ok) return;
        gid = int'(bus.GRANT_ID);
        repeat (lat) tick();
        bus.MEM_ACK = 1'b1; bus.MEM_DOUT = d;
        tick();
        bus.MEM_ACK = 1'b0; bus.MEM_DOUT = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.REQ = '1; bus.MEM_ACK = 1'b1; bus.MEM_DOUT = $urandom;
        for (int p = 0; p < N; p++) rand_cmd(p);
        repeat (3) tick();
        total++; if (bus.MEM_REQ !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", bus.MEM_REQ); end
        total++; if (bus.ACK !== '0) begin bad++; $display("FAIL reset_ack: got %b want 000", bus.ACK); end
        total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
        total++; if (bus.GRANT_ID !== '0) begin bad++; $display("FAIL reset_grant: got %0d want 0", bus.GRANT_ID); end
        total++; if (bus.DOUT !== '0) begin bad++; $display("FAIL reset_dout: got %h want 0", bus.DOUT); end
        total++; if ({bus.MEM_WE, bus.MEM_ADDR, bus.MEM_DIN, bus.MEM_BE} !== '0) begin bad++;
            $display("FAIL reset_mem_cmd: got %h want 0", {bus.MEM_WE, bus.MEM_ADDR, bus.MEM_DIN, bus.MEM_BE}); end
        do_reset();
        bus.REQ = 3'b110;
        tick();
        total++; if (bus.GRANT_ID !== 2'd1) begin bad++; $display("FAIL reset_first_rr: got %0d want 1", bus.GRANT_ID); end
    endtask

    task automatic test_single_read();
        do_reset();
        set_cmd(1, 1'b0, 22'h0ABCDE, 32'h0, 4'hF);
        bus.REQ[1] = 1'b1;
        tick();
        total++; if ({bus.MEM_REQ, bus.BUSY, bus.GRANT_ID, bus.MEM_WE, bus.MEM_ADDR} !== {1'b1, 1'b1, 2'd1, 1'b0, 22'h0ABCDE}) begin bad++;
            $display("FAIL read_issue: got req=%b busy=%b gid=%0d we=%b addr=%h want 1 1 1 0 0abcde",
                     bus.MEM_REQ, bus.BUSY, bus.GRANT_ID, bus.MEM_WE, bus.MEM_ADDR); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if ({bus.MEM_REQ, bus.ACK} !== 4'b1000) begin bad++;
                $display("FAIL read_wait: cycle %0d got req=%b ack=%b want 1 000", i, bus.MEM_REQ, bus.ACK); end
        end
        bus.MEM_ACK = 1'b1; bus.MEM_DOUT = 32'hDEADBEEF;
        tick();
        bus.MEM_ACK = 1'b0; bus.MEM_DOUT = 32'h0;
        total++; if ({bus.ACK, bus.DOUT, bus.GRANT_ID, bus.MEM_REQ} !== {3'b010, 32'hDEADBEEF, 2'd1, 1'b0}) begin bad++;
            $display("FAIL read_ack: got ack=%b dout=%h gid=%0d req=%b want 010 deadbeef 1 0",
                     bus.ACK, bus.DOUT, bus.GRANT_ID, bus.MEM_REQ); end
        bus.REQ[1] = 1'b0;
        tick();
        total++; if ({bus.ACK, bus.DOUT, bus.BUSY} !== {3'b000, 32'hDEADBEEF, 1'b0}) begin bad++;
            $display("FAIL read_after: got ack=%b dout=%h busy=%b want 000 deadbeef 0", bus.ACK, bus.DOUT, bus.BUSY); end
    endtask

    task automatic test_write_port2();
        logic [AW+DW+BW+1:0] want;
        do_reset();
        set_cmd(2, 1'b1, 22'h3FFFFF, 32'h12345678, 4'b0101);
        bus.REQ[2] = 1'b1;
        want = {1'b1, 1'b1, 22'h3FFFFF, 32'h12345678, 4'b0101};
        tick();
        for (int i = 0; i < 5; i++) begin
            total++; if ({bus.MEM_REQ, bus.MEM_WE, bus.MEM_ADDR, bus.MEM_DIN, bus.MEM_BE} !== want) begin bad++;
                $display("FAIL write_stable: cycle %0d got %h want %h", i,
                         {bus.MEM_REQ, bus.MEM_WE, bus.MEM_ADDR, bus.MEM_DIN, bus.MEM_BE}, want); end
            rand_cmd(2);
            bus.REQ[0] = 1'($urandom_range(0, 1));
            bus.REQ[1] = 1'($urandom_range(0, 1));
            tick();
        end
        bus.MEM_ACK = 1'b1;
        tick();
        bus.MEM_ACK = 1'b0;
        total++; if (bus.ACK !== 3'b100) begin bad++; $display("FAIL write_ack: got %b want 100", bus.ACK); end
        bus.REQ = '0;
        tick();
    endtask

    task automatic test_priority_0_2();
        int gid, waited; bit ok;
        do_reset();
        rand_cmd(0); rand_cmd(2);
        bus.REQ = 3'b101;
        serve(2, 32'hA0A0_0001, gid, waited, ok);
        total++; if (!ok || gid != 0 || waited != 1) begin bad++;
            $display("FAIL prio_first: got ok=%b gid=%0d wait=%0d want 1 0 1", ok, gid, waited); end
        total++; if ({bus.ACK, bus.DOUT} !== {3'b001, 32'hA0A0_0001}) begin bad++;
            $display("FAIL prio_ack0: got ack=%b dout=%h want 001 a0a00001", bus.ACK, bus.DOUT); end
        bus.REQ[0] = 1'b0;
        serve(1, 32'hA0A0_0002, gid, waited, ok);
        total++; if (!ok || gid != 2 || waited != 2) begin bad++;
            $display("FAIL prio_second: got ok=%b gid=%0d gap=%0d want 1 2 2", ok, gid, waited); end
        total++; if ({bus.ACK, bus.DOUT} !== {3'b100, 32'hA0A0_0002}) begin bad++;
            $display("FAIL prio_ack2: got ack=%b dout=%h want 100 a0a00002", bus.ACK, bus.DOUT); end
        bus.REQ = '0;
        tick();
    endtask

    task automatic test_starvation();
        int want[6];
        int gid, waited; bit ok;
        want = '{0, 0, 0, 0, 1, 0};
        do_reset();
        bus.REQ = 3'b011;
        for (int i = 0; i < 6; i++) begin
            serve(int'($urandom_range(0, 2)), $urandom, gid, waited, ok);
            total++; if (!ok || gid != want[i]) begin bad++;
                $display("FAIL starve_order: grant %0d got %0d (ok=%b) want %0d", i, gid, ok, want[i]); end
        end
        bus.REQ = '0;
        tick();
    endtask

    task automatic test_round_robin();
        int want[5];
        int gid, waited; bit ok;
        want = '{1, 2, 1, 2, 1};
        do_reset();
        bus.REQ = 3'b110;
        for (int i = 0; i < 5; i++) begin
            serve(int'($urandom_range(0, 2)), $urandom, gid, waited, ok);
            total++; if (!ok || gid != want[i] || (i > 0 && waited != 2)) begin bad++;
                $display("FAIL rr_order: grant %0d got %0d gap=%0d (ok=%b) want %0d gap 2", i, gid, waited, ok, want[i]); end
        end
        bus.REQ = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        int gid, waited; bit ok;
        do_reset();
        rand_cmd(2);
        bus.REQ[2] = 1'b1;
        tick();
        total++; if (bus.MEM_REQ !== 1'b1) begin bad++; $display("FAIL midrst_issue: got %b want 1", bus.MEM_REQ); end
        tick();
        rst = 1'b1; bus.MEM_ACK = 1'b1;
        tick();
        total++; if ({bus.MEM_REQ, bus.ACK, bus.BUSY} !== 5'b0_000_0) begin bad++;
            $display("FAIL midrst_abort: got req=%b ack=%b busy=%b want 0 000 0", bus.MEM_REQ, bus.ACK, bus.BUSY); end
        rst = 1'b0; bus.MEM_ACK = 1'b0; bus.REQ = '0;
        m_last = N - 1; m_starve = 0;
        repeat (2) tick();
        bus.MEM_ACK = 1'b1; bus.MEM_DOUT = 32'hBAD0_BAD0;
        tick();
        bus.MEM_ACK = 1'b0;
        tick();
        total++; if ({bus.ACK, bus.BUSY, bus.DOUT} !== {3'b000, 1'b0, 32'h0}) begin bad++;
            $display("FAIL stray_mem_ack: got ack=%b busy=%b dout=%h want 000 0 0", bus.ACK, bus.BUSY, bus.DOUT); end
        rand_cmd(1);
        bus.REQ[1] = 1'b1;
        serve(1, 32'h5555_AAAA, gid, waited, ok);
        total++; if (!ok || gid != 1 || bus.ACK !== 3'b010 || bus.DOUT !== 32'h5555_AAAA) begin bad++;
            $display("FAIL midrst_recover: got ok=%b gid=%0d ack=%b dout=%h want 1 1 010 5555aaaa", ok, gid, bus.ACK, bus.DOUT); end
        bus.REQ = '0;
        tick();
    endtask

    task automatic test_random();
        bit               e_mreq, e_busy, n_mreq, n_busy, free, acked;
        logic [N-1:0]     e_ack, n_ack;
        logic [DW-1:0]    e_dout, n_dout, d;
        logic [1:0]       e_gid;
        logic [AW+DW+BW:0] e_cmd;
        int               cnt, lat, w;
        do_reset();
        e_mreq = 0; e_busy = 0; e_ack = '0; e_dout = '0; e_gid = '0; e_cmd = '0;
        free = 1; cnt = 0; lat = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            total++; if ({bus.MEM_REQ, bus.BUSY, bus.ACK} !== {e_mreq, e_busy, e_ack}) begin bad++;
                $display("FAIL rnd_ctrl: cyc %0d got req=%b busy=%b ack=%b want %b %b %b",
                         cyc, bus.MEM_REQ, bus.BUSY, bus.ACK, e_mreq, e_busy, e_ack); end
            total++; if ({bus.DOUT, bus.GRANT_ID} !== {e_dout, e_gid}) begin bad++;
                $display("FAIL rnd_dout_gid: cyc %0d got dout=%h gid=%0d want %h %0d", cyc, bus.DOUT, bus.GRANT_ID, e_dout, e_gid); end
            total++; if ({bus.MEM_WE, bus.MEM_ADDR, bus.MEM_DIN, bus.MEM_BE} !== e_cmd) begin bad++;
                $display("FAIL rnd_mem_cmd: cyc %0d got %h want %h", cyc,
                         {bus.MEM_WE, bus.MEM_ADDR, bus.MEM_DIN, bus.MEM_BE}, e_cmd); end

            acked = (e_ack != '0);
            n_ack = '0; n_mreq = e_mreq; n_busy = e_busy; n_dout = e_dout;
            if (acked) begin
                bus.REQ[e_gid] = 1'b0;
                n_busy = 0;
            end
            if (e_mreq) begin
                cnt++;
                if (cnt >= lat) begin
                    d = $urandom;
                    bus.MEM_ACK = 1'b1; bus.MEM_DOUT = d;
                    n_ack[e_gid] = 1'b1; n_dout = d; n_mreq = 0;
                end else begin
                    bus.MEM_ACK = 1'b0; bus.MEM_DOUT = $urandom;
                end
            end else begin
                bus.MEM_ACK = ($urandom_range(0, 3) == 0); bus.MEM_DOUT = $urandom;
            end
            for (int p = 0; p < N; p++) begin
                if (acked && p == int'(e_gid)) continue;
                if (e_busy && p == int'(e_gid)) rand_cmd(p);
                else if (!bus.REQ[p]) begin
                    rand_cmd(p);
                    if ($urandom_range(0, 3) == 0) bus.REQ[p] = 1'b1;
                end else if ($urandom_range(0, 19) == 0) bus.REQ[p] = 1'b0;
            end
            if (free && bus.REQ != '0) begin
                w = model_pick(bus.REQ);
                e_gid = 2'(w);
                e_cmd = {bus.REQ_WE[w], bus.REQ_ADDR[w*AW +: AW], bus.REQ_DIN[w*DW +: DW], bus.REQ_BE[w*BW +: BW]};
                n_mreq = 1; n_busy = 1; free = 0; cnt = 0;
                lat = int'($urandom_range(0, 4));
            end
            if (acked) free = 1;
            e_mreq = n_mreq; e_busy = n_busy; e_ack = n_ack; e_dout = n_dout;
            tick();
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_write_port2();
        test_priority_0_2();
        test_starvation();
        test_round_robin();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
